// File: rtl/pipe_hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: slot tag layout, select and register constants.
package pipe_pkg;
  localparam int PKG_REG_W   = 5;
  localparam int FWD_REGFILE = 0;

  typedef logic [PKG_REG_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

  typedef struct packed {
    logic     valid;
    reg_idx_t rw;
    logic     is_load;
  } slot_t;

  // A slot is a producer of src only when it is live and not targeting r0.
  function automatic logic slot_hit(slot_t s, reg_idx_t src);
    return s.valid && (s.rw != REG_ZERO) && (s.rw == src);
  endfunction
endpackage

// File: rtl/pipe_hazard_scoreboard_if.sv
// Decode-side bundle between the ID stage and the hazard scoreboard.
interface pipe_hazard_scoreboard_if #(
  parameter int REG_W = 5,
  parameter int FWD_W = 2,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_rs_used;
  logic             id_rt_used;
  logic [REG_W-1:0] id_rw;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             flush;
  logic [FWD_W-1:0] fwd_a;
  logic [FWD_W-1:0] fwd_b;
  logic             stall;
  logic             bubble;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
           id_rw, id_reg_write, id_mem_read, flush,
    input  fwd_a, fwd_b, stall, bubble, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
           id_rw, id_reg_write, id_mem_read, flush,
    output fwd_a, fwd_b, stall, bubble, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_scoreboard_tag_match.sv
// Priority matcher: youngest slot producing a source register, plus load-use flag.
module pipe_tag_match
  import pipe_pkg::*;
#(
  parameter int STAGES     = 3,
  parameter int LOAD_STAGE = 2,
  parameter int FWD_W      = $clog2(STAGES + 1)
) (
  input  slot_t [STAGES:1] slots,
  input  reg_idx_t         src,
  input  logic             used,
  output logic [FWD_W-1:0] sel,
  output logic             load_hz
);
  logic found;

  always_comb begin
    sel     = FWD_W'(FWD_REGFILE);
    load_hz = 1'b0;
    found   = 1'b0;
    // Slot 1 is the youngest, so the first hit in ascending order wins.
    for (int k = 1; k <= STAGES; k++) begin
      if (!found && used && slot_hit(slots[k], src)) begin
        found   = 1'b1;
        sel     = FWD_W'(k);
        load_hz = slots[k].is_load && (k < LOAD_STAGE);
      end
    end
  end
endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// Tag-chain hazard scoreboard: forwarding selects, load-use stall, bubble, perf counters.
module pipe_hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int NREG       = 32,
  parameter int REG_W      = 5,
  parameter int STAGES     = 3,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 16,
  parameter int FWD_W      = $clog2(STAGES + 1)
) (
  input logic                    CLK,
  input logic                    Reset_L,
  pipe_hazard_scoreboard_if.slave bus
);
  if (STAGES < 2 || STAGES > 8) begin : g_bad_stages
    $error("pipe_hazard_scoreboard: STAGES must be 2..8");
  end
  if (LOAD_STAGE < 1 || LOAD_STAGE > STAGES) begin : g_bad_load
    $error("pipe_hazard_scoreboard: LOAD_STAGE must be 1..STAGES");
  end
  if (REG_W != PKG_REG_W || NREG != (1 << REG_W)) begin : g_bad_reg
    $error("pipe_hazard_scoreboard: REG_W/NREG disagree with pipe_pkg");
  end

  slot_t [STAGES:1] slots;
  slot_t            slot_in;
  logic [FWD_W-1:0] sel_a, sel_b;
  logic             hz_a, hz_b;
  logic             hazard, stall, bubble;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipe_tag_match #(.STAGES(STAGES), .LOAD_STAGE(LOAD_STAGE), .FWD_W(FWD_W)) u_match_rs (
    .slots   (slots),
    .src     (bus.id_rs),
    .used    (bus.id_rs_used),
    .sel     (sel_a),
    .load_hz (hz_a)
  );

  pipe_tag_match #(.STAGES(STAGES), .LOAD_STAGE(LOAD_STAGE), .FWD_W(FWD_W)) u_match_rt (
    .slots   (slots),
    .src     (bus.id_rt),
    .used    (bus.id_rt_used),
    .sel     (sel_b),
    .load_hz (hz_b)
  );

  // Flush dominates: a squashed instruction never stalls and never enters slot 1.
  assign hazard = hz_a | hz_b;
  assign stall  = bus.id_valid & ~bus.flush & hazard;
  assign bubble = stall | bus.flush;

  always_comb begin
    slot_in = '0;
    if (!bubble) begin
      slot_in.valid   = bus.id_valid & bus.id_reg_write & (bus.id_rw != REG_ZERO);
      slot_in.rw      = bus.id_rw;
      slot_in.is_load = bus.id_mem_read;
    end
  end

  always_ff @(negedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      slots <= '0;
    end else begin
      for (int k = STAGES; k >= 2; k--) slots[k] <= slots[k-1];
      slots[1] <= slot_in;
    end
  end

  always_ff @(negedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (bus.flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign bus.fwd_a     = sel_a;
  assign bus.fwd_b     = sel_b;
  assign bus.stall     = stall;
  assign bus.bubble    = bubble;
  assign bus.stall_cnt = stall_cnt;
  assign bus.flush_cnt = flush_cnt;
endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Bench for pipe_hazard_scoreboard: instruction-stream table plus saturation and async-reset sequences.
module tb_pipe_hazard_scoreboard;
  localparam int CNT_W = 4;
  localparam int FWD_W = 2;

  typedef struct {
    int v, rs, rt, ru, tu, rw, wr, mr, fl;
    int fa, fb, st, bb, sc, fc;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  vec_t tbl[19];
  vec_t expq[$];

  pipe_hazard_scoreboard_if #(.REG_W(5), .FWD_W(FWD_W), .CNT_W(CNT_W)) bus ();

  pipe_hazard_scoreboard #(.STAGES(3), .LOAD_STAGE(2), .CNT_W(CNT_W)) u_dut (
    .CLK     (clk),
    .Reset_L (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t x);
    bus.id_valid     = x.v[0];
    bus.id_rs        = x.rs[4:0];
    bus.id_rt        = x.rt[4:0];
    bus.id_rs_used   = x.ru[0];
    bus.id_rt_used   = x.tu[0];
    bus.id_rw        = x.rw[4:0];
    bus.id_reg_write = x.wr[0];
    bus.id_mem_read  = x.mr[0];
    bus.flush        = x.fl[0];
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " fwd_a"}, int'(bus.fwd_a), 0);
    chk({tag, " fwd_b"}, int'(bus.fwd_b), 0);
    chk({tag, " stall"}, int'(bus.stall), 0);
    chk({tag, " bubble"}, int'(bus.bubble), 0);
    chk({tag, " stall_cnt"}, int'(bus.stall_cnt), 0);
    chk({tag, " flush_cnt"}, int'(bus.flush_cnt), 0);
  endtask

  // Drive one decode cycle after the update edge, compare mid-cycle against the queued expectation.
  task automatic step_vec(input vec_t x, input int idx);
    vec_t e;
    string n;
    @(negedge clk);
    #1;
    drive(x);
    expq.push_back(x);
    #3;
    e = expq.pop_front();
    n = $sformatf("v%0d", idx);
    chk({n, " fwd_a"}, int'(bus.fwd_a), e.fa);
    chk({n, " fwd_b"}, int'(bus.fwd_b), e.fb);
    chk({n, " stall"}, int'(bus.stall), e.st);
    chk({n, " bubble"}, int'(bus.bubble), e.bb);
    chk({n, " stall_cnt"}, int'(bus.stall_cnt), e.sc);
    chk({n, " flush_cnt"}, int'(bus.flush_cnt), e.fc);
  endtask

  initial begin
    vec_t lw5, idle;
    checks = 0;
    errors = 0;
    //          v  rs  rt ru tu rw  wr mr fl  fa fb st bb sc fc
    tbl[0]  = '{1, 1,  2, 1, 1, 3,  1, 0, 0,  0, 0, 0, 0, 0, 0}; // add r3,r1,r2
    tbl[1]  = '{1, 3,  3, 1, 1, 4,  1, 0, 0,  1, 1, 0, 0, 0, 0}; // add r4,r3,r3
    tbl[2]  = '{1, 1,  5, 1, 0, 5,  1, 1, 0,  0, 0, 0, 0, 0, 0}; // lw r5
    tbl[3]  = '{1, 5,  1, 1, 1, 6,  1, 0, 0,  1, 0, 1, 1, 0, 0}; // add r6,r5,r1 stalls
    tbl[4]  = '{1, 5,  1, 1, 1, 6,  1, 0, 0,  2, 0, 0, 0, 1, 0}; // replay, load in slot 2
    tbl[5]  = '{1, 0,  0, 1, 1, 0,  1, 0, 0,  0, 0, 0, 0, 1, 0}; // write r0
    tbl[6]  = '{1, 0,  6, 1, 1, 0,  0, 0, 0,  0, 2, 0, 0, 1, 0}; // read r0, r6
    tbl[7]  = '{1, 6,  7, 1, 1, 7,  1, 0, 0,  3, 0, 0, 0, 1, 0}; // WB slot forwards
    tbl[8]  = '{1, 1,  2, 1, 1, 9,  1, 0, 0,  0, 0, 0, 0, 1, 0};
    tbl[9]  = '{1, 7,  9, 1, 1, 7,  1, 0, 0,  2, 1, 0, 0, 1, 0}; // second r7 writer
    tbl[10] = '{0, 7,  9, 1, 1, 0,  0, 0, 0,  1, 2, 0, 0, 1, 0}; // youngest r7 wins
    tbl[11] = '{1, 7,  9, 1, 1, 0,  0, 0, 0,  2, 3, 0, 0, 1, 0}; // after idle bubble
    tbl[12] = '{1, 1,  0, 1, 0, 10, 1, 1, 0,  0, 0, 0, 0, 1, 0}; // lw r10
    tbl[13] = '{1, 10, 1, 1, 1, 11, 1, 0, 1,  1, 0, 0, 1, 1, 0}; // hazard + flush
    tbl[14] = '{0, 10, 0, 1, 0, 0,  0, 0, 0,  2, 0, 0, 0, 1, 1}; // slot 1 empty
    tbl[15] = '{1, 0,  10, 0, 1, 0, 0, 0, 0,  0, 3, 0, 0, 1, 1}; // load in WB: no stall
    tbl[16] = '{1, 1,  0, 1, 0, 13, 1, 1, 0,  0, 0, 0, 0, 1, 1}; // lw r13
    tbl[17] = '{1, 1,  13, 1, 1, 14, 1, 0, 0, 0, 1, 1, 1, 1, 1}; // rt load-use
    tbl[18] = '{1, 1,  13, 1, 1, 14, 1, 0, 0, 0, 2, 0, 0, 2, 1};

    lw5  = '{1, 5, 0, 1, 0, 5, 1, 1, 0,  0, 0, 0, 0, 0, 0};      // lw r5,0(r5)
    idle = '{1, 1, 2, 1, 1, 3, 1, 0, 0,  0, 0, 0, 0, 0, 0};

    rst_n = 1'b0;
    drive('{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0});
    #2;
    check_zero("reset");
    #5 rst_n = 1'b1;

    for (int i = 0; i < 19; i++) step_vec(tbl[i], i);

    // Self-dependent load stalls every other cycle; counter must pin at all-ones.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1 drive(lw5);
    end
    #3;
    chk("sat stall_cnt", int'(bus.stall_cnt), 15);
    chk("sat flush_cnt", int'(bus.flush_cnt), 1);

    begin
      int n;
      n = 0;
      while (!bus.stall && n < 10) begin
        @(negedge clk);
        #4;
        n++;
      end
    end
    chk("pre-reset stall", int'(bus.stall), 1);
    rst_n = 1'b0;
    #1;
    check_zero("async reset");
    #2 rst_n = 1'b1;
    step_vec(idle, 99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_scoreboard.md
# pipe_hazard_scoreboard

Parametrised hazard-detection and forwarding-select unit for the pipelined MIPS core. It replaces the fixed three-stage hazard/forwarding pair with a tag scoreboard of configurable depth. The unit sits beside the decode stage. It tracks the destination register of every in-flight instruction after decode. It produces per-operand forwarding selects, the load-use stall, and the bubble injection. It also keeps saturating stall and flush counters for performance debug.

## Interface
- `NREG`, 32: architectural register count; register 0 is hard-wired zero.
- `REG_W`, 5: register index width, equal to log2(`NREG`).
- `STAGES`, 3: post-decode stages tracked (EX..WB). Legal range is 2..8.
- `LOAD_STAGE`, 2: first slot at which load data can be forwarded. Legal range is 1..`STAGES`.
- `CNT_W`, 16: width of the performance counters.
- `FWD_W`, $clog2(`STAGES`+1): width of the forwarding selects (derived).

- `CLK`  in  1  clock; all state updates on the negedge, matching the core.
- `Reset_L`  in  1  reset, asynchronous, active-low.
- `id_valid`  in  1  the decode stage holds a real instruction.
- `id_rs`, `id_rt`  in  `REG_W`  source register indices.
- `id_rs_used`, `id_rt_used`  in  1  the corresponding source is actually read.
- `id_rw`  in  `REG_W`  destination register index.
- `id_reg_write`  in  1  the decode instruction writes `id_rw`.
- `id_mem_read`  in  1  the decode instruction is a load.
- `flush`  in  1  squash the decode instruction (taken branch or jump).
- `fwd_a`, `fwd_b`  out  `FWD_W`  operand source select. 0 means the register file; k means the result of slot k.
- `stall`  out  1  hold PC and IF/ID. The core drives PCWrite and IFWrite as ~`stall`.
- `bubble`  out  1  inject a NOP into slot 1 on this edge.
- `stall_cnt`, `flush_cnt`  out  `CNT_W`  saturating event counters.

## Operation
- State is a tag chain, slot[1..`STAGES`]. Each slot holds {valid, rw, is_load}.
- Each negedge shifts the chain: slot[k] takes slot[k-1] for k≥2, and slot[`STAGES`] is discarded.
- Slot 1 loads {id_valid & id_reg_write & (id_rw≠0), id_rw, id_mem_read}, except when `bubble`=1. In that case slot 1 loads all-zero.
- A slot can only match if valid=1 and rw≠0. Register 0 never forwards and never stalls.
- **Forwarding selects.** For each used source, the select is the smallest k with a matching slot, so the youngest producer wins. If the source has no match or is unused, the select is 0. Both selects are combinational from the slots and the decode inputs.
- **Hazard.** A hazard exists when the youngest match for a used source has is_load=1 and k<`LOAD_STAGE`.
- `stall` = id_valid & ~flush & hazard.
- `bubble` = stall | flush.
- **Simultaneous flush and hazard.** Flush wins: `stall`=0 and `bubble`=1. The squashed instruction never occupies slot 1.
- **Stall duration.** A stall lasts until the load reaches slot `LOAD_STAGE`. That is (`LOAD_STAGE` − k) cycles for a load first matched at slot k. Each stall cycle inserts one bubble.
- **Counters.** `stall_cnt` increments on each negedge where `stall`=1. `flush_cnt` increments on each negedge where `flush`=1. Both saturate at all-ones and never wrap.
- **Reset.** `Reset_L` low asynchronously clears all slots and both counters. It may arrive mid-stall; the stall is abandoned.
- **Reset values.** `fwd_a`=`fwd_b`=0, `stall`=0, `bubble`=0 (with `flush` low), counters 0.
- The `LOAD_STAGE` and `STAGES` range checks are elaboration-time assertions.

## Timing
- Outputs are combinational from the decode inputs and the slot state. They must be stable before the negedge.
- The datapath registers `fwd_a` and `fwd_b` into ID/EX alongside the operands.
- Scoreboard latency is one cycle: a producer decoded at edge n is visible in slot 1 after edge n.
- There is no timing dependency on regfile write ordering. Slot `STAGES` (WB) still forwards.

## Structure
- Shared package `pipe_pkg` holds:
  - the slot struct typedef (valid, rw, is_load);
  - the constant FWD_REGFILE = 0;
  - the register-0 constant.
- Sub-module `pipe_tag_match` is a priority matcher. Its inputs are the slot vector, a source index and a used flag. Its outputs are the select and a load-hazard flag. It is instantiated once for rs and once for rt.
- The top level holds the slot shift chain, the stall/bubble logic and the counters.

## Test plan
All scenarios use `STAGES`=3 and `LOAD_STAGE`=2 unless stated otherwise.

- **ALU back-to-back.** Decode `add r3,r1,r2`, then `add r4,r3,r3` → `fwd_a`=`fwd_b`=1, `stall`=0.
- **Load-use.** Decode `lw r5`, then `add r6,r5,r1` → `stall`=`bubble`=1 for exactly one cycle, `stall_cnt`=1. Next cycle `fwd_a`=2 and `stall`=0.
- **Register 0.** A write to r0 followed by a read of r0 → `fwd_a`=0, `stall`=0. Slot 1 is invalid after the edge.
- **Youngest producer.** r7 is written by the instructions in slots 1 and 3 → `fwd_a`=1. After one idle bubble, `fwd_a`=2.
- **Flush over hazard.** A load-use hazard with `flush`=1 in the same cycle → `stall`=0, `bubble`=1, `flush_cnt`=1. Slot 1 is invalid after the edge.
- **Saturation and reset.** With `CNT_W`=4, force 20 stall cycles → `stall_cnt`=15. Drop `Reset_L` between edges → all outputs and counters read 0 immediately.
